// File: rtl/stream_fork.sv
// Registered one-to-two broadcast stage: each accepted word is offered to two
// consumers that handshake independently; a new word enters only once both have taken the old one.
module stream_fork #(
  parameter int DataWidth = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        valid_i,
  input  logic signed [DataWidth-1:0] c_i,
  output logic                        ready_o,
  output logic                        valid_a_o,
  output logic signed [DataWidth-1:0] a_o,
  input  logic                        ready_a_i,
  output logic                        valid_b_o,
  output logic signed [DataWidth-1:0] b_o,
  input  logic                        ready_b_i,
  output logic [1:0]                  state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. Once raised, a valid holds with stable data until its ready.
  // Valids come straight from flops; ready_o depends only on the branch readys.

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ONLY_B = 2'b01,
    ONLY_A = 2'b10,
    BOTH   = 2'b11
  } state_e;

  state_e                      state_q, state_d;
  logic signed [DataWidth-1:0] data_q, data_d;
  logic                        pend_a, pend_b;
  logic                        done_a, done_b;
  logic                        accept;

  assign pend_a  = state_q[1];
  assign pend_b  = state_q[0];
  assign done_a  = ~pend_a | ready_a_i;
  assign done_b  = ~pend_b | ready_b_i;
  // Held low during reset so upstream never sees a transfer that gets lost.
  assign ready_o = done_a & done_b & reset_ni;
  assign accept  = valid_i & ready_o;

  assign valid_a_o = pend_a;
  assign valid_b_o = pend_b;
  assign a_o       = data_q;
  assign b_o       = data_q;
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (accept) begin
      state_d = BOTH;
      data_d  = c_i;
    end else begin
      state_d = state_e'({pend_a & ~ready_a_i, pend_b & ~ready_b_i});
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_stream_fork.sv
// Directed and randomised-ready checks for stream_fork with immediate assertions
// and an expected-word queue per branch.
module tb_stream_fork;

  localparam int W = 32;
  localparam int NRAND = 1000;

  logic                clk_i;
  logic                reset_ni;
  logic                valid_i;
  logic signed [W-1:0] c_i;
  logic                ready_o;
  logic                valid_a_o;
  logic signed [W-1:0] a_o;
  logic                ready_a_i;
  logic                valid_b_o;
  logic signed [W-1:0] b_o;
  logic                ready_b_i;
  logic [1:0]          state_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  stream_fork #(.DataWidth(W)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .valid_i  (valid_i),
    .c_i      (c_i),
    .ready_o  (ready_o),
    .valid_a_o(valid_a_o),
    .a_o      (a_o),
    .ready_a_i(ready_a_i),
    .valid_b_o(valid_b_o),
    .b_o      (b_o),
    .ready_b_i(ready_b_i),
    .state_o  (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  logic [W-1:0] words [8];
  logic [W-1:0] cur_word, hold_a, hold_b, wv;
  logic         hold_a_v, hold_b_v;
  int           sent, got_a, got_b, cyc;

  initial begin
    words[0] = 32'h0000_0001; words[1] = 32'hFFFF_FFFF;
    words[2] = 32'h7FFF_FFFF; words[3] = 32'h8000_0000;
    words[4] = 32'h0000_0002; words[5] = 32'hFFFF_FFFE;
    words[6] = 32'h1234_5678; words[7] = 32'h0000_0000;

    // Reset held with upstream valid: everything stays zero.
    reset_ni = 1'b0; valid_i = 1'b1; c_i = 32'sd5; ready_a_i = 1'b1; ready_b_i = 1'b1;
    tick();
    tick();
    chk("rst_ready", ready_o, 0);
    chk("rst_valid_a", valid_a_o, 0);
    chk("rst_valid_b", valid_b_o, 0);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_state", state_o, 2'b00);

    // Release and pass one word through.
    reset_ni = 1'b1;
    #1;
    chk("rel_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk("pt_valid_a", valid_a_o, 1);
    chk("pt_valid_b", valid_b_o, 1);
    chk("pt_a", a_o, 5);
    chk("pt_b", b_o, 5);
    tick();
    chk("pt_drop_a", valid_a_o, 0);
    chk("pt_drop_b", valid_b_o, 0);

    // Back-to-back streaming with both consumers always ready.
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1; c_i = words[i];
      #1;
      chk("str_ready", ready_o, 1);
      tick();
      chk("str_valid_a", valid_a_o, 1);
      chk("str_valid_b", valid_b_o, 1);
      chk("str_a", a_o, words[i]);
      chk("str_b", b_o, words[i]);
    end
    valid_i = 1'b0;
    tick();
    chk("str_empty", state_o, 2'b00);

    // Skewed acceptance: A ready, B stalled for three cycles.
    ready_a_i = 1'b1; ready_b_i = 1'b0; valid_i = 1'b1; c_i = 32'h1234;
    tick();
    chk("skw_valid_a0", valid_a_o, 1);
    chk("skw_valid_b0", valid_b_o, 1);
    c_i = 32'h5678;
    #1;
    chk("skw_ready0", ready_o, 0);
    for (int k = 1; k < 3; k++) begin
      tick();
      chk("skw_valid_a", valid_a_o, 0);
      chk("skw_valid_b", valid_b_o, 1);
      chk("skw_b", b_o, 32'h1234);
      chk("skw_state", state_o, 2'b01);
      #1;
      chk("skw_ready", ready_o, 0);
    end
    ready_b_i = 1'b1;
    #1;
    chk("skw_ready_rise", ready_o, 1);
    tick();
    chk("skw2_valid_a", valid_a_o, 1);
    chk("skw2_valid_b", valid_b_o, 1);
    chk("skw2_a", a_o, 32'h5678);
    valid_i = 1'b0;
    tick();
    chk("skw_empty", state_o, 2'b00);

    // Simultaneous release of both branches together with a new word.
    ready_a_i = 1'b0; ready_b_i = 1'b0; valid_i = 1'b1; c_i = 32'hA;
    tick();
    c_i = 32'hB;
    #1;
    chk("sim_ready_block", ready_o, 0);
    tick();
    chk("sim_hold_a", a_o, 32'hA);
    chk("sim_hold_state", state_o, 2'b11);
    ready_a_i = 1'b1; ready_b_i = 1'b1;
    #1;
    chk("sim_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    chk("sim_valid_a", valid_a_o, 1);
    chk("sim_valid_b", valid_b_o, 1);
    chk("sim_a", a_o, 32'hB);
    chk("sim_b", b_o, 32'hB);
    tick();
    chk("sim_empty", state_o, 2'b00);

    // Random ready toggling against a per-branch expected queue.
    sent = 0; got_a = 0; got_b = 0; cyc = 0;
    hold_a_v = 1'b0; hold_b_v = 1'b0; hold_a = '0; hold_b = '0;
    cur_word = $urandom;
    while ((got_a < NRAND || got_b < NRAND) && cyc < 20000) begin
      valid_i   = (sent < NRAND);
      c_i       = cur_word;
      ready_a_i = 1'($urandom_range(0, 1));
      ready_b_i = 1'($urandom_range(0, 1));
      #1;
      if (hold_a_v) begin
        chk("rnd_hold_valid_a", valid_a_o, 1);
        chk("rnd_hold_a", a_o, hold_a);
      end
      if (hold_b_v) begin
        chk("rnd_hold_valid_b", valid_b_o, 1);
        chk("rnd_hold_b", b_o, hold_b);
      end
      if (valid_a_o && ready_a_i) begin
        if (exp_a_q.size() > 0) begin
          wv = exp_a_q.pop_front();
          chk("rnd_a", a_o, wv);
        end else chk("rnd_a_extra", exp_a_q.size(), 1);
        got_a++;
      end
      if (valid_b_o && ready_b_i) begin
        if (exp_b_q.size() > 0) begin
          wv = exp_b_q.pop_front();
          chk("rnd_b", b_o, wv);
        end else chk("rnd_b_extra", exp_b_q.size(), 1);
        got_b++;
      end
      hold_a_v = valid_a_o & ~ready_a_i; hold_a = a_o;
      hold_b_v = valid_b_o & ~ready_b_i; hold_b = b_o;
      if (valid_i && ready_o) begin
        exp_a_q.push_back(c_i);
        exp_b_q.push_back(c_i);
        sent++;
        cur_word = $urandom;
      end
      tick();
      cyc++;
    end
    valid_i = 1'b0;
    chk("rnd_sent", sent, NRAND);
    chk("rnd_got_a", got_a, NRAND);
    chk("rnd_got_b", got_b, NRAND);
    chk("rnd_left_a", exp_a_q.size(), 0);
    chk("rnd_left_b", exp_b_q.size(), 0);
    ready_a_i = 1'b1; ready_b_i = 1'b1;
    tick();
    chk("rnd_empty", state_o, 2'b00);

    // Asynchronous reset while B still owes acceptance.
    ready_a_i = 1'b1; ready_b_i = 1'b0; valid_i = 1'b1; c_i = 32'h77;
    tick();
    valid_i = 1'b0;
    tick();
    chk("mr_state", state_o, 2'b01);
    chk("mr_valid_b", valid_b_o, 1);
    chk("mr_b", b_o, 32'h77);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("mr_drop_b", valid_b_o, 0);
    chk("mr_b_zero", b_o, 0);
    chk("mr_ready_low", ready_o, 0);
    chk("mr_state_rst", state_o, 2'b00);
    #1;
    reset_ni = 1'b1;
    tick();
    chk("mr_after_state", state_o, 2'b00);
    chk("mr_after_ready", ready_o, 1);
    chk("mr_after_valid_b", valid_b_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fork.md
# stream_fork

Registered one-to-two broadcast stage for the valid/ready stream protocol used by the DSP and fixed-point pipeline blocks. It accepts one signed word per handshake and presents it to two independent consumers, for example two adder operand ports or an adder and a FIFO. Each consumer handshakes independently. A new word is accepted only once both consumers have taken the current one, with full throughput when both sinks are ready.

## Interface
Parameters:
- DataWidth, 32, width of the signed data word.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  reset; asynchronous, active-low.
- valid_i  input  1  upstream word valid.
- c_i  input  DataWidth (signed)  upstream word.
- ready_o  output  1  stage can accept a word this cycle.
- valid_a_o  output  1  branch A word valid.
- a_o  output  DataWidth (signed)  branch A word.
- ready_a_i  input  1  branch A consumer ready.
- valid_b_o  output  1  branch B word valid.
- b_o  output  DataWidth (signed)  branch B word.
- ready_b_i  input  1  branch B consumer ready.

## Operation
- State: data_q [DataWidth-1:0], plus pending flags pend_a_q and pend_b_q.
- FSM encoding {pend_a_q, pend_b_q}:
  - EMPTY = 00
  - BOTH = 11
  - ONLY_A = 10 (A still owes acceptance)
  - ONLY_B = 01
- Outputs:
  - valid_a_o = pend_a_q and valid_b_o = pend_b_q.
  - a_o = b_o = data_q, with no arithmetic and no width change.
- done_a = ~pend_a_q | ready_a_i; done_b = ~pend_b_q | ready_b_i.
- ready_o = done_a & done_b, forced 0 while reset_ni is low.
- Accept (valid_i & ready_o): data_q <= c_i, pend_a_q <= 1, pend_b_q <= 1. This covers a branch consuming the old word in the same cycle.
- No accept: pend_x_q <= pend_x_q & ~ready_x_i for each branch; data_q holds.
- Transitions:
  - EMPTY to BOTH on accept.
  - BOTH to ONLY_B when A alone accepts.
  - BOTH to ONLY_A when B alone accepts.
  - BOTH to EMPTY when both accept with no new valid_i.
  - BOTH to BOTH when both accept while valid_i is high (back-to-back).
  - ONLY_x to EMPTY, or to BOTH if valid_i, when x accepts.
- A branch that has accepted deasserts its valid and never sees the same word twice.
- data_q is stable while either valid is high.
- valid_a_o and valid_b_o never drop without the matching ready, except on reset.
- ready_a_i and ready_b_i may toggle freely. Valid outputs do not depend on ready inputs combinationally.
- ready_o depends combinationally on ready_a_i and ready_b_i only, never on valid_i.

## Timing
- Reset, asynchronous while reset_ni = 0:
  - pend_a_q = pend_b_q = 0, data_q = 0.
  - valid_a_o = valid_b_o = 0, a_o = b_o = 0, ready_o = 0.
- First cycle after reset release: ready_o = 1 (state EMPTY).
- Latency: a word accepted at edge N appears on a_o/b_o with valids high after edge N.
- Throughput: 1 word/cycle while ready_a_i = ready_b_i = 1.
- Throughput is otherwise limited by the slower branch.
- Branch skew: if A accepts at edge N and B at edge N+k, ready_o is high in the cycle B accepts, so the next word is taken at edge N+k.
- Reset asserted mid-transfer: pending words are discarded and valids drop immediately (asynchronously).

## Test plan
- Reset and pass-through:
  - Hold reset_ni = 0 with valid_i = 1: all outputs stay 0.
  - Release, send c_i = 0x0000_0005 with both readys high: one cycle later a_o = b_o = 5 with both valids high.
  - Both valids drop the following cycle.
- Streaming: send 8 back-to-back words (1, -1, 0x7FFF_FFFF, 0x8000_0000, ...) with both readys held at 1.
  - ready_o stays 1 throughout.
  - Each branch receives all 8 words in order, one per cycle.
- Skewed acceptance: send 0x1234 with ready_a_i = 1 and ready_b_i = 0 for 3 cycles.
  - valid_a_o is high for exactly 1 cycle; valid_b_o stays high with b_o = 0x1234.
  - ready_o = 0 and a second word is held upstream.
  - Raise ready_b_i: the second word is accepted in that same cycle.
- Simultaneous release with new input: from BOTH holding 0xA, assert ready_a_i, ready_b_i and valid_i with 0xB together.
  - The next cycle shows a_o = b_o = 0xB with both valids high, and no bubble.
- Random ready toggling: 1000 words with independent random readys.
  - Both branch sequences match the input sequence exactly, with no loss or duplication.
  - data_q never changes while either valid is high without the matching handshake.
- Mid-operation reset: in state ONLY_B, pulse reset_ni low between clock edges.
  - valid_b_o drops immediately.
  - After release the state is EMPTY and ready_o = 1.
